// File: rtl/s2mm_burst_arbiter.sv
// s2mm_burst_arbiter
//   Shares one AXI4 write port between two AXI-Stream capture channels.
//   Bursts are granted round-robin; each burst is a fixed-length INCR burst
//   starting at the granted channel's buffer-manager address, and the granted
//   stream is passed straight through onto the W channel.
//
// Ports
//   aclk, areset            clock, synchronous active-high reset
//   s{0,1}_axis_*           capture streams (tdata/tvalid in, tready out)
//   s{0,1}_address          current write address from each buffer manager
//   s{0,1}_writing          one-cycle strobe per beat stored for that channel
//   m_axi_aw*/w*/b*         AXI4 write-only master port
//   grant                   channel owning the current or most recent burst
//   error                   sticky per-channel bad-BRESP flags
//
// Build option
//   S2MM_BURST_ARBITER_BRESP_CHECK_EN : when defined, a non-OKAY BRESP sets
//   error[grant] until reset; when undefined, bresp is ignored and error=0.
module s2mm_burst_arbiter #(
    parameter int MM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int LOG_BURST_LEN = 4
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [DATA_WIDTH-1:0]    s0_axis_tdata,
    input  logic                     s0_axis_tvalid,
    output logic                     s0_axis_tready,
    input  logic [MM_ADDR_WIDTH-1:0] s0_address,
    output logic                     s0_writing,
    input  logic [DATA_WIDTH-1:0]    s1_axis_tdata,
    input  logic                     s1_axis_tvalid,
    output logic                     s1_axis_tready,
    input  logic [MM_ADDR_WIDTH-1:0] s1_address,
    output logic                     s1_writing,
    output logic [MM_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]               m_axi_awlen,
    output logic [2:0]               m_axi_awsize,
    output logic [1:0]               m_axi_awburst,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [DATA_WIDTH-1:0]    m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]  m_axi_wstrb,
    output logic                     m_axi_wlast,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic                     grant,
    output logic [1:0]               error
);

    localparam int BURST_LEN = 1 << LOG_BURST_LEN;
    localparam int CNT_W     = (LOG_BURST_LEN > 0) ? LOG_BURST_LEN : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_e;

    state_e                   state_q, state_d;
    logic                     grant_q, grant_d;
    logic                     rr_q, rr_d;
    logic [MM_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                     awvalid_q, awvalid_d;
    logic [CNT_W-1:0]         beat_q, beat_d;

    logic                     in_data;
    logic                     sel_tvalid;
    logic                     w_hs;
    logic                     pick;

    always_comb begin
        in_data    = (state_q == ST_DATA);
        sel_tvalid = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
        w_hs       = in_data && sel_tvalid && m_axi_wready;
        // Both requesting: the pointer decides; otherwise whichever requests.
        pick       = (s0_axis_tvalid && s1_axis_tvalid) ? rr_q : s1_axis_tvalid;

        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        awaddr_d  = awaddr_q;
        awvalid_d = awvalid_q;
        beat_d    = beat_q;

        case (state_q)
            ST_IDLE: begin
                if (s0_axis_tvalid || s1_axis_tvalid) begin
                    grant_d   = pick;
                    awaddr_d  = pick ? s1_address : s0_address;
                    awvalid_d = 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi_awready) begin
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid) begin
                    rr_d    = ~rr_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            rr_q      <= 1'b0;
            awaddr_q  <= '0;
            awvalid_q <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            awaddr_q  <= awaddr_d;
            awvalid_q <= awvalid_d;
            beat_q    <= beat_d;
        end
    end

`ifdef S2MM_BURST_ARBITER_BRESP_CHECK_EN
    logic [1:0] error_q, error_d;

    always_comb begin
        error_d = error_q;
        if ((state_q == ST_RESP) && m_axi_bvalid && (m_axi_bresp != 2'b00)) begin
            error_d[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            error_q <= '0;
        end else begin
            error_q <= error_d;
        end
    end

    always_comb error = error_q;
`else
    logic unused_bresp;

    always_comb begin
        unused_bresp = ^m_axi_bresp;
        error        = '0;
    end
`endif

    // W channel and stream readies are pure pass-through of the granted
    // channel, gated to the DATA state so nothing leaks between bursts.
    always_comb begin
        m_axi_awaddr   = awaddr_q;
        m_axi_awvalid  = awvalid_q;
        m_axi_awlen    = 8'(BURST_LEN - 1);
        m_axi_awsize   = 3'($clog2(DATA_WIDTH / 8));
        m_axi_awburst  = 2'b01;
        m_axi_wdata    = grant_q ? s1_axis_tdata : s0_axis_tdata;
        m_axi_wstrb    = '1;
        m_axi_wvalid   = in_data && sel_tvalid;
        m_axi_wlast    = in_data && (beat_q == LAST_BEAT);
        m_axi_bready   = (state_q == ST_RESP);
        s0_axis_tready = in_data && !grant_q && m_axi_wready;
        s1_axis_tready = in_data &&  grant_q && m_axi_wready;
        s0_writing     = w_hs && !grant_q;
        s1_writing     = w_hs &&  grant_q;
        grant          = grant_q;
    end

endmodule

// File: tb/tb_s2mm_burst_arbiter.sv
module tb_s2mm_burst_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LOGB  = 4;
    localparam int BL    = 16;
    localparam int BYTES = DW / 8;

    logic            aclk;
    logic            areset;
    logic [DW-1:0]   s0_axis_tdata, s1_axis_tdata;
    logic            s0_axis_tvalid, s1_axis_tvalid;
    logic            s0_axis_tready, s1_axis_tready;
    logic [AW-1:0]   s0_address, s1_address;
    logic            s0_writing, s1_writing;
    logic [AW-1:0]   m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic            m_axi_awvalid, m_axi_awready;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid, m_axi_bready;
    logic            grant;
    logic [1:0]      error;

    s2mm_burst_arbiter #(
        .MM_ADDR_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .LOG_BURST_LEN (LOGB)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tready (s0_axis_tready),
        .s0_address     (s0_address),
        .s0_writing     (s0_writing),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tready (s1_axis_tready),
        .s1_address     (s1_address),
        .s1_writing     (s1_writing),
        .m_axi_awaddr   (m_axi_awaddr),
        .m_axi_awlen    (m_axi_awlen),
        .m_axi_awsize   (m_axi_awsize),
        .m_axi_awburst  (m_axi_awburst),
        .m_axi_awvalid  (m_axi_awvalid),
        .m_axi_awready  (m_axi_awready),
        .m_axi_wdata    (m_axi_wdata),
        .m_axi_wstrb    (m_axi_wstrb),
        .m_axi_wlast    (m_axi_wlast),
        .m_axi_wvalid   (m_axi_wvalid),
        .m_axi_wready   (m_axi_wready),
        .m_axi_bresp    (m_axi_bresp),
        .m_axi_bvalid   (m_axi_bvalid),
        .m_axi_bready   (m_axi_bready),
        .grant          (grant),
        .error          (error)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Stimulus configuration and per-channel source state.
    int            remaining[2] = '{0, 0};
    int            seq[2]       = '{0, 0};
    int            stall_left[2] = '{0, 0};
    int            wcount[2]    = '{0, 0};
    bit            acc[2]       = '{0, 0};
    logic [AW-1:0] base[2];
    int            phase_id = 0;
    int            vprob = 100, wr_mode = 0, aw_delay = 0, aw_rand = 0;
    int            bprob = 100, bad_pct = 0, stall_ch = -1, hold_req = -1;
    int            aw_cnt = 0;

    // Scoreboard: expected beats and burst addresses per channel.
    logic [DW-1:0] exp_w0[$], exp_w1[$];
    logic [AW-1:0] exp_aw0[$], exp_aw1[$];

    // Monitor-side transaction tracking.
    bit            in_data = 0, resp_pending = 0;
    int            cur = 0, beat = 0, rr = 0, aw_hold = 0;
    logic [1:0]    err_exp = 2'b00;
    logic [AW-1:0] aw_prev;
    bit            aw_prev_v = 0;
    int            aw_n = 0, w_n = 0, wlast_n = 0;
    int            wr_n[2] = '{0, 0};
    logic [AW-1:0] first_aw;
    int            grant_log[$];

    function automatic logic [DW-1:0] mk(input int c, input int ph, input int s);
        return DW'((ph << 24) | (c << 20) | s);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source driver: streams, buffer-manager addresses, slave-side AXI responses.
    initial begin : driver
        logic [1:0]    tv;
        logic [DW-1:0] td[2];
        logic [AW-1:0] ad[2];
        s0_axis_tvalid = 0; s1_axis_tvalid = 0;
        s0_axis_tdata  = '0; s1_axis_tdata  = '0;
        s0_address     = '0; s1_address     = '0;
        m_axi_awready  = 0; m_axi_wready = 0;
        m_axi_bvalid   = 0; m_axi_bresp  = 2'b00;
        base[0] = '0; base[1] = '0;
        forever begin
            @(posedge aclk);
            #1;
            for (int c = 0; c < 2; c++) begin
                if (acc[c] && remaining[c] > 0) begin
                    seq[c]++;
                    remaining[c]--;
                    if (stall_ch == c && seq[c] == 8) stall_left[c] = 10;
                end
                if (stall_left[c] > 0) begin
                    tv[c] = 1'b0;
                    stall_left[c]--;
                end else begin
                    tv[c] = (remaining[c] > 0) &&
                            ((seq[c] % BL) == 0 || $urandom_range(99) < vprob);
                end
                td[c] = mk(c, phase_id, seq[c]);
                ad[c] = base[c] + AW'(wcount[c] * BYTES);
            end
            s0_axis_tvalid = tv[0]; s1_axis_tvalid = tv[1];
            s0_axis_tdata  = td[0]; s1_axis_tdata  = td[1];
            s0_address     = ad[0]; s1_address     = ad[1];
            case (wr_mode)
                0:       m_axi_wready = 1'b1;
                1:       m_axi_wready = ~m_axi_wready;
                default: m_axi_wready = ($urandom_range(99) < 70);
            endcase
            if (!m_axi_awvalid) begin
                aw_cnt = 0;
            end else begin
                aw_cnt++;
                if (aw_cnt == 1 && aw_rand != 0) aw_delay = $urandom_range(3);
            end
            m_axi_awready = m_axi_awvalid && (aw_cnt > aw_delay);
            m_axi_bvalid  = resp_pending && ($urandom_range(99) < bprob);
            m_axi_bresp   = (m_axi_bvalid && $urandom_range(99) < bad_pct) ? 2'b10 : 2'b00;
        end
    end

    // Monitor: per-cycle protocol checks plus scoreboard pops on handshakes.
    initial begin : monitor
        logic [1:0]    tv, tr, wr;
        bit            old_in, old_resp;
        int            eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        forever begin
            @(negedge aclk);
            if (areset) begin
                acc[0] = 0; acc[1] = 0;
                continue;
            end
            tv = {s1_axis_tvalid, s0_axis_tvalid};
            tr = {s1_axis_tready, s0_axis_tready};
            wr = {s1_writing, s0_writing};
            old_in   = in_data;
            old_resp = resp_pending;

            chk("wvalid", m_axi_wvalid, old_in && tv[cur]);
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("tready%0d", c), tr[c], old_in && cur == c && m_axi_wready);
                chk($sformatf("writing%0d", c), wr[c],
                    old_in && cur == c && tv[c] && m_axi_wready);
            end
            chk("bready", m_axi_bready, old_resp);
            if (old_in || old_resp) chk("awvalid_in_burst", m_axi_awvalid, 0);
            if (old_in) chk("grant_hold", grant, cur);
            chk("error", error, err_exp);
            if (aw_prev_v && m_axi_awvalid) chk("awaddr_stable", m_axi_awaddr, aw_prev);

            if (m_axi_awvalid) aw_hold++;
            if (m_axi_awvalid && m_axi_awready) begin
                eg = (remaining[0] > 0 && remaining[1] > 0) ? rr : (remaining[0] > 0 ? 0 : 1);
                chk("aw_grant", grant, eg);
                chk("aw_expected", ((eg == 0) ? exp_aw0.size() : exp_aw1.size()) > 0, 1);
                ea = '0;
                if (eg == 0 && exp_aw0.size() > 0) ea = exp_aw0.pop_front();
                if (eg == 1 && exp_aw1.size() > 0) ea = exp_aw1.pop_front();
                chk("awaddr", m_axi_awaddr, ea);
                chk("awlen", m_axi_awlen, BL - 1);
                chk("awsize", m_axi_awsize, 2);
                chk("awburst", m_axi_awburst, 1);
                if (hold_req >= 0) chk("aw_hold_cycles", aw_hold, hold_req);
                grant_log.push_back(int'(grant));
                if (aw_n == 0) first_aw = m_axi_awaddr;
                aw_n++;
                in_data = 1;
                cur     = eg;
                beat    = 0;
            end
            if (!m_axi_awvalid || m_axi_awready) aw_hold = 0;
            aw_prev   = m_axi_awaddr;
            aw_prev_v = m_axi_awvalid && !m_axi_awready;

            if (old_in && m_axi_wvalid && m_axi_wready) begin
                chk("w_expected", ((cur == 0) ? exp_w0.size() : exp_w1.size()) > 0, 1);
                ew = '0;
                if (cur == 0 && exp_w0.size() > 0) ew = exp_w0.pop_front();
                if (cur == 1 && exp_w1.size() > 0) ew = exp_w1.pop_front();
                chk("wdata", m_axi_wdata, ew);
                chk("wlast", m_axi_wlast, beat == BL - 1);
                chk("wstrb", m_axi_wstrb, {(DW/8){1'b1}});
                w_n++;
                if (m_axi_wlast) wlast_n++;
                beat++;
                if (beat == BL) begin
                    in_data      = 0;
                    resp_pending = 1;
                end
            end

            if (old_resp && m_axi_bvalid && m_axi_bready) begin
                rr = 1 - rr;
                resp_pending = 0;
`ifdef S2MM_BURST_ARBITER_BRESP_CHECK_EN
                if (m_axi_bresp != 2'b00) err_exp[cur] = 1'b1;
`endif
            end

            for (int c = 0; c < 2; c++) begin
                acc[c] = tv[c] && tr[c];
                if (wr[c]) begin
                    wcount[c]++;
                    wr_n[c]++;
                end
            end
        end
    end

    task automatic flush();
        exp_w0.delete(); exp_w1.delete(); exp_aw0.delete(); exp_aw1.delete();
        in_data = 0; resp_pending = 0; rr = 0; err_exp = 2'b00;
        aw_hold = 0; aw_prev_v = 0;
        for (int c = 0; c < 2; c++) begin
            remaining[c] = 0; seq[c] = 0; stall_left[c] = 0; wcount[c] = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #2;
        areset = 1'b1;
        remaining[0] = 0; remaining[1] = 0;
        @(posedge aclk);
        #2;
        areset = 1'b0;
        flush();
    endtask

    task automatic check_reset_state();
        @(negedge aclk);
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_awaddr", m_axi_awaddr, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_wlast", m_axi_wlast, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_tready", {s1_axis_tready, s0_axis_tready}, 0);
        chk("rst_writing", {s1_writing, s0_writing}, 0);
        chk("rst_grant", grant, 0);
        chk("rst_error", error, 0);
    endtask

    task automatic start_phase(input int n0, input int n1,
                               input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                               input int vp, input int wm, input int awd, input int awr,
                               input int bp, input int bad, input int stl, input int hold);
        @(posedge aclk);
        #2;
        phase_id++;
        vprob = vp; wr_mode = wm; aw_delay = awd; aw_rand = awr;
        bprob = bp; bad_pct = bad; stall_ch = stl; hold_req = hold;
        base[0] = b0; base[1] = b1;
        aw_n = 0; w_n = 0; wlast_n = 0; wr_n[0] = 0; wr_n[1] = 0;
        grant_log.delete();
        for (int c = 0; c < 2; c++) begin
            seq[c] = 0; wcount[c] = 0; stall_left[c] = 0;
        end
        for (int i = 0; i < n0; i++) exp_w0.push_back(mk(0, phase_id, i));
        for (int i = 0; i < n1; i++) exp_w1.push_back(mk(1, phase_id, i));
        for (int k = 0; k < n0 / BL; k++) exp_aw0.push_back(b0 + AW'(k * BL * BYTES));
        for (int k = 0; k < n1 / BL; k++) exp_aw1.push_back(b1 + AW'(k * BL * BYTES));
        remaining[0] = n0;
        remaining[1] = n1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            @(posedge aclk);
            #2;
            n++;
            done = (remaining[0] == 0) && (remaining[1] == 0) &&
                   (exp_w0.size() == 0) && (exp_w1.size() == 0) &&
                   !in_data && !resp_pending;
        end
        chk("phase_complete", done, 1);
    endtask

    initial begin : main
        int n0, n1, n;
        areset = 1'b1;
        do_reset();
        check_reset_state();

        // Single channel: 32 beats on ch0, everything always ready.
        start_phase(32, 0, 32'h1000_0000, 32'h2000_0000, 100, 0, 0, 0, 100, 0, -1, -1);
        wait_done(1000);
        chk("single_aw_count", aw_n, 2);
        chk("single_first_aw", first_aw, 32'h1000_0000);
        chk("single_w_count", w_n, 32);
        chk("single_wlast_count", wlast_n, 2);
        chk("single_writing0", wr_n[0], 32);
        chk("single_writing1", wr_n[1], 0);

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        start_phase(32, 32, 32'h1000_0000, 32'h2000_0000, 100, 0, 0, 0, 100, 0, -1, -1);
        wait_done(1000);
        chk("contention_bursts", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk($sformatf("contention_grant%0d", i), grant_log[i], i % 2);

        // Backpressure: wready toggles, awready after 5 cycles of awvalid.
        start_phase(16, 0, 32'h3000_0000, 32'h2000_0000, 100, 1, 5, 0, 100, 0, -1, 6);
        wait_done(1000);
        chk("bp_writing0", wr_n[0], 16);
        chk("bp_w_count", w_n, 16);
        chk("bp_wlast_count", wlast_n, 1);

        // Stream stall on ch0 after beat 7 while ch1 keeps requesting.
        start_phase(32, 32, 32'h4000_0000, 32'h5000_0000, 100, 0, 0, 0, 100, 0, 0, -1);
        wait_done(1500);

        // Mid-burst reset after ch0 beat 5, then a fresh contended start.
        start_phase(32, 16, 32'h6000_0000, 32'h7000_0000, 100, 0, 0, 0, 100, 0, -1, -1);
        n = 0;
        while (seq[0] < 6 && n < 500) begin
            @(posedge aclk);
            #2;
            n++;
        end
        chk("midreset_reached_beat6", seq[0] >= 6, 1);
        do_reset();
        check_reset_state();
        start_phase(16, 16, 32'h6000_0000, 32'h7000_0000, 100, 0, 0, 0, 100, 0, -1, -1);
        wait_done(1000);
        chk("post_reset_bursts", grant_log.size(), 2);
        if (grant_log.size() > 0) chk("post_reset_first_grant", grant_log[0], 0);

        // Randomised traffic with random stalls, backpressure and bad responses.
        for (int p = 0; p < 8; p++) begin
            n0 = BL * $urandom_range(3);
            n1 = BL * $urandom_range(3);
            if (n0 == 0 && n1 == 0) n1 = BL;
            start_phase(n0, n1, $urandom & 32'hFFFF_F000, $urandom & 32'hFFFF_F000,
                        75, 2, 0, 1, 60, 20, -1, -1);
            wait_done(3000);
            chk("rand_w_count", w_n, n0 + n1);
        end

        repeat (2) @(negedge aclk);
        chk("final_error", error, err_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
